// File: rtl/alu_rs.sv
// alu_rs: reservation station and issue scheduler for the integer ALU.
// Holds up to RS_SIZE decoded ALU/branch/jump instructions. Operands still
// pending are captured from the ALU and load/store CDB broadcasts. Each
// cycle, the lowest-index ready slot is copied to registered ALU operands.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rdy                   global enable (0 freezes all state)
//   flush                 misprediction clear from the ROB
//   issue_*               decoded instruction from the decoder
//   rs_full               no free slot (combinational from slot state)
//   alu_cdb_*, lsb_cdb_*  result broadcasts
//   new_calculate, out_*  registered ALU operand bundle
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [5:0]       issue_op,
  input  logic [31:0]      issue_instruction,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_entry,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [TAG_W-1:0] alu_cdb_entry,
  input  logic [31:0]      alu_cdb_result,
  input  logic             lsb_cdb_valid,
  input  logic [TAG_W-1:0] lsb_cdb_entry,
  input  logic [31:0]      lsb_cdb_result,
  output logic             new_calculate,
  output logic [5:0]       out_op,
  output logic [31:0]      out_instruction,
  output logic [31:0]      out_vj,
  output logic [31:0]      out_vk,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [TAG_W-1:0] out_entry
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Slot storage
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [5:0]         op          [RS_SIZE];
  logic [31:0]        instruction [RS_SIZE];
  logic [31:0]        pc          [RS_SIZE];
  logic [31:0]        imm         [RS_SIZE];
  logic [TAG_W-1:0]   entry       [RS_SIZE];
  logic [TAG_W-1:0]   qj          [RS_SIZE];
  logic [TAG_W-1:0]   qk          [RS_SIZE];
  logic [31:0]        vj          [RS_SIZE];
  logic [31:0]        vk          [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               byp_qj_busy;
  logic               byp_qk_busy;
  logic [31:0]        byp_vj;
  logic [31:0]        byp_vk;

  assign ready   = busy & ~qj_busy & ~qk_busy;
  assign rs_full = &busy;

  // Lowest free slot and lowest ready slot, both from start-of-cycle state
  always_comb begin
    free_idx = {IDX_W{1'b0}};
    sel_idx  = {IDX_W{1'b0}};
    // Scanning downwards leaves the lowest matching index in place
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
      end else begin
        free_idx = free_idx;
      end
      if (ready[i]) begin
        sel_idx = IDX_W'(i);
      end else begin
        sel_idx = sel_idx;
      end
    end
  end

  // Issue-time bypass: capture an operand broadcast in the same cycle it is issued
  always_comb begin
    byp_qj_busy = issue_qj_busy;
    byp_vj      = issue_vj;
    byp_qk_busy = issue_qk_busy;
    byp_vk      = issue_vk;
    // ALU CDB is checked first so it wins if both were to match
    if (issue_qj_busy && alu_cdb_valid && (issue_qj == alu_cdb_entry)) begin
      byp_qj_busy = 1'b0;
      byp_vj      = alu_cdb_result;
    end else if (issue_qj_busy && lsb_cdb_valid && (issue_qj == lsb_cdb_entry)) begin
      byp_qj_busy = 1'b0;
      byp_vj      = lsb_cdb_result;
    end else begin
      byp_qj_busy = issue_qj_busy;
    end
    if (issue_qk_busy && alu_cdb_valid && (issue_qk == alu_cdb_entry)) begin
      byp_qk_busy = 1'b0;
      byp_vk      = alu_cdb_result;
    end else if (issue_qk_busy && lsb_cdb_valid && (issue_qk == lsb_cdb_entry)) begin
      byp_qk_busy = 1'b0;
      byp_vk      = lsb_cdb_result;
    end else begin
      byp_qk_busy = issue_qk_busy;
    end
  end

  // Slot state, wakeup, dispatch and allocation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy            <= {RS_SIZE{1'b0}};
      qj_busy         <= {RS_SIZE{1'b0}};
      qk_busy         <= {RS_SIZE{1'b0}};
      new_calculate   <= 1'b0;
      out_op          <= 6'd0;
      out_instruction <= 32'd0;
      out_vj          <= 32'd0;
      out_vk          <= 32'd0;
      out_pc          <= 32'd0;
      out_imm         <= 32'd0;
      out_entry       <= {TAG_W{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i]          <= 6'd0;
        instruction[i] <= 32'd0;
        pc[i]          <= 32'd0;
        imm[i]         <= 32'd0;
        entry[i]       <= {TAG_W{1'b0}};
        qj[i]          <= {TAG_W{1'b0}};
        qk[i]          <= {TAG_W{1'b0}};
        vj[i]          <= 32'd0;
        vk[i]          <= 32'd0;
      end
    end else if (flush) begin
      busy          <= {RS_SIZE{1'b0}};
      new_calculate <= 1'b0;
    end else if (!rdy) begin
      new_calculate <= 1'b0;
    end else begin
      // Wakeup: any number of waiting slots may capture one broadcast
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && qj_busy[i]) begin
          if (alu_cdb_valid && (qj[i] == alu_cdb_entry)) begin
            vj[i]      <= alu_cdb_result;
            qj_busy[i] <= 1'b0;
          end else if (lsb_cdb_valid && (qj[i] == lsb_cdb_entry)) begin
            vj[i]      <= lsb_cdb_result;
            qj_busy[i] <= 1'b0;
          end else begin
            qj_busy[i] <= 1'b1;
          end
        end else begin
          qj_busy[i] <= qj_busy[i];
        end
        if (busy[i] && qk_busy[i]) begin
          if (alu_cdb_valid && (qk[i] == alu_cdb_entry)) begin
            vk[i]      <= alu_cdb_result;
            qk_busy[i] <= 1'b0;
          end else if (lsb_cdb_valid && (qk[i] == lsb_cdb_entry)) begin
            vk[i]      <= lsb_cdb_result;
            qk_busy[i] <= 1'b0;
          end else begin
            qk_busy[i] <= 1'b1;
          end
        end else begin
          qk_busy[i] <= qk_busy[i];
        end
      end

      // Dispatch: a ready slot has no pending operand, so wakeup never touches it
      if (|ready) begin
        new_calculate   <= 1'b1;
        out_op          <= op[sel_idx];
        out_instruction <= instruction[sel_idx];
        out_vj          <= vj[sel_idx];
        out_vk          <= vk[sel_idx];
        out_pc          <= pc[sel_idx];
        out_imm         <= imm[sel_idx];
        out_entry       <= entry[sel_idx];
        busy[sel_idx]   <= 1'b0;
      end else begin
        new_calculate <= 1'b0;
      end

      // Allocation: the free slot was idle at start of cycle, so it never
      // collides with the dispatched slot or a wakeup target
      if (issue_valid && !rs_full) begin
        busy[free_idx]        <= 1'b1;
        op[free_idx]          <= issue_op;
        instruction[free_idx] <= issue_instruction;
        pc[free_idx]          <= issue_pc;
        imm[free_idx]         <= issue_imm;
        entry[free_idx]       <= issue_entry;
        qj[free_idx]          <= issue_qj;
        qk[free_idx]          <= issue_qk;
        qj_busy[free_idx]     <= byp_qj_busy;
        qk_busy[free_idx]     <= byp_qk_busy;
        vj[free_idx]          <= byp_vj;
        vk[free_idx]          <= byp_vk;
      end else begin
        busy[free_idx] <= busy[free_idx] & ~(|ready && (sel_idx == free_idx));
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: self-checking bench for alu_rs. A slot-list reference model
// runs alongside the DUT; a compare process checks every output on every
// falling edge, and directed scenarios add hand-computed expectations.
module tb_alu_rs;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy, flush, issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_instruction, issue_pc, issue_imm, issue_vj, issue_vk;
  logic        issue_qj_busy, issue_qk_busy;
  logic [3:0]  issue_qj, issue_qk, issue_entry;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_entry, lsb_cdb_entry;
  logic [31:0] alu_cdb_result, lsb_cdb_result;
  logic        new_calculate;
  logic [5:0]  out_op;
  logic [31:0] out_instruction, out_vj, out_vk, out_pc, out_imm;
  logic [3:0]  out_entry;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_rs #(.RS_SIZE(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_instruction(issue_instruction), .issue_pc(issue_pc),
    .issue_imm(issue_imm), .issue_qj_busy(issue_qj_busy),
    .issue_qk_busy(issue_qk_busy), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_entry(issue_entry),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_entry(alu_cdb_entry),
    .alu_cdb_result(alu_cdb_result),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_entry(lsb_cdb_entry),
    .lsb_cdb_result(lsb_cdb_result),
    .new_calculate(new_calculate), .out_op(out_op),
    .out_instruction(out_instruction), .out_vj(out_vj), .out_vk(out_vk),
    .out_pc(out_pc), .out_imm(out_imm), .out_entry(out_entry)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] ins, pc, imm, vj, vk;
    logic [3:0]  ent, qj, qk;
    bit          qjb, qkb;
  } slot_t;

  slot_t       m [8];
  bit          e_nc;
  logic [5:0]  e_op;
  logic [31:0] e_ins, e_vj, e_vk, e_pc, e_imm;
  logic [3:0]  e_ent;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m[i].busy = 1'b0;
      m[i].qjb  = 1'b0;
      m[i].qkb  = 1'b0;
    end
    e_nc = 1'b0; e_op = 6'd0; e_ins = 32'd0; e_vj = 32'd0;
    e_vk = 32'd0; e_pc = 32'd0; e_imm = 32'd0; e_ent = 4'd0;
  endtask

  // Resolve an operand against the broadcasts; ALU CDB has priority
  task automatic snoop(inout bit pend, input logic [3:0] tag, inout logic [31:0] val);
    if (pend && alu_cdb_valid && tag == alu_cdb_entry) begin
      pend = 1'b0; val = alu_cdb_result;
    end else if (pend && lsb_cdb_valid && tag == lsb_cdb_entry) begin
      pend = 1'b0; val = lsb_cdb_result;
    end
  endtask

  task automatic model_step();
    int sel, fr;
    if (rst) begin model_reset(); return; end
    if (flush) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      e_nc = 1'b0;
      return;
    end
    if (!rdy) begin e_nc = 1'b0; return; end
    sel = -1; fr = -1;
    for (int i = 0; i < 8; i++) begin
      if (!m[i].busy && fr < 0) fr = i;
      if (m[i].busy && !m[i].qjb && !m[i].qkb && sel < 0) sel = i;
    end
    if (sel >= 0) begin
      e_nc = 1'b1; e_op = m[sel].op; e_ins = m[sel].ins; e_vj = m[sel].vj;
      e_vk = m[sel].vk; e_pc = m[sel].pc; e_imm = m[sel].imm; e_ent = m[sel].ent;
    end else begin
      e_nc = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m[i].busy) begin
        snoop(m[i].qjb, m[i].qj, m[i].vj);
        snoop(m[i].qkb, m[i].qk, m[i].vk);
      end
    end
    if (sel >= 0) m[sel].busy = 1'b0;
    if (issue_valid && fr >= 0) begin
      m[fr].busy = 1'b1; m[fr].op = issue_op; m[fr].ins = issue_instruction;
      m[fr].pc = issue_pc; m[fr].imm = issue_imm; m[fr].ent = issue_entry;
      m[fr].qj = issue_qj; m[fr].qk = issue_qk;
      m[fr].qjb = issue_qj_busy; m[fr].qkb = issue_qk_busy;
      m[fr].vj = issue_vj; m[fr].vk = issue_vk;
      snoop(m[fr].qjb, m[fr].qj, m[fr].vj);
      snoop(m[fr].qkb, m[fr].qk, m[fr].vk);
    end
  endtask

  function automatic bit model_full();
    bit f = 1'b1;
    for (int i = 0; i < 8; i++) f &= m[i].busy;
    return f;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every output against the model on each falling edge
  always @(negedge clk) begin
    chk("new_calculate", {31'd0, new_calculate}, {31'd0, e_nc});
    chk("rs_full", {31'd0, rs_full}, {31'd0, model_full()});
    chk("out_op", {26'd0, out_op}, {26'd0, e_op});
    chk("out_instruction", out_instruction, e_ins);
    chk("out_vj", out_vj, e_vj);
    chk("out_vk", out_vk, e_vk);
    chk("out_pc", out_pc, e_pc);
    chk("out_imm", out_imm, e_imm);
    chk("out_entry", {28'd0, out_entry}, {28'd0, e_ent});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
  endtask

  task automatic issue_ins(input logic [5:0] o, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [31:0] imm, input logic [3:0] ent,
                           input logic qjb, input logic [3:0] qj,
                           input logic qkb, input logic [3:0] qk);
    issue_valid = 1'b1; issue_op = o; issue_vj = vj; issue_vk = vk; issue_imm = imm;
    issue_entry = ent; issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb;
    issue_qk = qk; issue_pc = 32'h1000 + {28'd0, ent}; issue_instruction = 32'h13 + {28'd0, ent};
  endtask

  task automatic randomize_inputs();
    rdy = ($urandom_range(9) != 0);
    flush = ($urandom_range(39) == 0);
    issue_valid = $urandom_range(1);
    issue_op = 6'($urandom); issue_instruction = $urandom; issue_pc = $urandom;
    issue_imm = $urandom; issue_vj = $urandom; issue_vk = $urandom;
    issue_entry = 4'($urandom);
    issue_qj_busy = ($urandom_range(4) < 2); issue_qj = 4'($urandom_range(7));
    issue_qk_busy = ($urandom_range(4) < 2); issue_qk = 4'($urandom_range(7));
    alu_cdb_valid = ($urandom_range(9) < 3); alu_cdb_entry = 4'($urandom_range(7));
    alu_cdb_result = $urandom;
    lsb_cdb_valid = ($urandom_range(9) < 3); lsb_cdb_entry = 4'($urandom_range(7));
    lsb_cdb_result = $urandom;
    if (alu_cdb_valid && lsb_cdb_valid && alu_cdb_entry == lsb_cdb_entry)
      lsb_cdb_entry = lsb_cdb_entry ^ 4'd1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    idle();
    issue_op = 6'd0; issue_instruction = 32'd0; issue_pc = 32'd0; issue_imm = 32'd0;
    issue_vj = 32'd0; issue_vk = 32'd0; issue_entry = 4'd0;
    issue_qj_busy = 1'b0; issue_qk_busy = 1'b0; issue_qj = 4'd0; issue_qk = 4'd0;
    alu_cdb_entry = 4'd0; lsb_cdb_entry = 4'd0; alu_cdb_result = 32'd0; lsb_cdb_result = 32'd0;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset new_calculate", {31'd0, new_calculate}, 32'd0);
    chk("reset rs_full", {31'd0, rs_full}, 32'd0);
    chk("reset out_vj", out_vj, 32'd0);
    chk("reset out_entry", {28'd0, out_entry}, 32'd0);

    // ADDI with ready operands: on the ALU two cycles after issue
    issue_ins(OP_ADDI, 32'd5, 32'd0, 32'd7, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    cyc(); idle();
    chk("addi not yet", {31'd0, new_calculate}, 32'd0);
    cyc();
    chk("addi nc", {31'd0, new_calculate}, 32'd1);
    chk("addi vj", out_vj, 32'd5);
    chk("addi imm", out_imm, 32'd7);
    chk("addi entry", {28'd0, out_entry}, 32'd3);
    chk("addi op", {26'd0, out_op}, {26'd0, OP_ADDI});
    cyc();

    // ADD waiting on tag 2, woken by the ALU CDB
    issue_ins(OP_ADD, 32'd0, 32'd1, 32'd0, 4'd4, 1'b1, 4'd2, 1'b0, 4'd0);
    cyc(); idle(); cyc();
    alu_cdb_valid = 1'b1; alu_cdb_entry = 4'd2; alu_cdb_result = 32'h10;
    cyc(); idle();
    chk("add waiting", {31'd0, new_calculate}, 32'd0);
    cyc();
    chk("add nc", {31'd0, new_calculate}, 32'd1);
    chk("add vj", out_vj, 32'h10);
    chk("add entry", {28'd0, out_entry}, 32'd4);
    cyc();

    // SUB bypass from the load/store CDB at issue
    issue_ins(OP_SUB, 32'd9, 32'd0, 32'd0, 4'd5, 1'b0, 4'd0, 1'b1, 4'd6);
    lsb_cdb_valid = 1'b1; lsb_cdb_entry = 4'd6; lsb_cdb_result = 32'hFFFF_FFFF;
    cyc(); idle();
    cyc();
    chk("bypass nc", {31'd0, new_calculate}, 32'd1);
    chk("bypass vk", out_vk, 32'hFFFF_FFFF);
    chk("bypass entry", {28'd0, out_entry}, 32'd5);
    cyc();

    // Fill all slots, drop a 9th issue, then drain in slot order
    for (int k = 0; k < 8; k++) begin
      issue_ins(OP_ADD, 32'd0, 32'(k), 32'd0, 4'(k), 1'b1, 4'd9, 1'b0, 4'd0);
      cyc();
    end
    chk("fill rs_full", {31'd0, rs_full}, 32'd1);
    issue_ins(OP_ADDI, 32'd1, 32'd1, 32'd1, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0);
    cyc(); idle();
    chk("full drop rs_full", {31'd0, rs_full}, 32'd1);
    alu_cdb_valid = 1'b1; alu_cdb_entry = 4'd9; alu_cdb_result = 32'h100;
    cyc(); idle();
    chk("fill woken not yet", {31'd0, new_calculate}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("drain nc", {31'd0, new_calculate}, 32'd1);
      chk("drain entry", {28'd0, out_entry}, 32'(k));
      chk("drain vj", out_vj, 32'h100);
      if (k == 0) chk("drain rs_full drop", {31'd0, rs_full}, 32'd0);
    end
    cyc();
    chk("dropped never dispatched", {31'd0, new_calculate}, 32'd0);

    // Flush with 4 waiting slots plus a same-cycle issue and wakeup
    for (int k = 0; k < 4; k++) begin
      issue_ins(OP_ADD, 32'd0, 32'd0, 32'd0, 4'(k), 1'b1, 4'd10, 1'b0, 4'd0);
      cyc();
    end
    issue_ins(OP_ADDI, 32'd3, 32'd3, 32'd3, 4'd12, 1'b0, 4'd0, 1'b0, 4'd0);
    flush = 1'b1; alu_cdb_valid = 1'b1; alu_cdb_entry = 4'd10; alu_cdb_result = 32'h55;
    cyc(); idle();
    chk("flush nc", {31'd0, new_calculate}, 32'd0);
    chk("flush rs_full", {31'd0, rs_full}, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_entry = 4'd10; alu_cdb_result = 32'h55;
    cyc(); idle();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post flush nc", {31'd0, new_calculate}, 32'd0);
    end

    // Stall with two ready slots, then resume in slot order
    issue_ins(OP_ADD, 32'd0, 32'd0, 32'd0, 4'd6, 1'b1, 4'd11, 1'b0, 4'd0);
    cyc();
    issue_ins(OP_ADD, 32'd0, 32'd0, 32'd0, 4'd7, 1'b1, 4'd11, 1'b0, 4'd0);
    cyc(); idle();
    alu_cdb_valid = 1'b1; alu_cdb_entry = 4'd11; alu_cdb_result = 32'h77;
    cyc(); idle();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall nc", {31'd0, new_calculate}, 32'd0);
    end
    rdy = 1'b1;
    cyc();
    chk("resume first nc", {31'd0, new_calculate}, 32'd1);
    chk("resume first entry", {28'd0, out_entry}, 32'd6);
    cyc();
    chk("resume second entry", {28'd0, out_entry}, 32'd7);
    chk("resume second vj", out_vj, 32'h77);
    cyc();
    chk("resume done", {31'd0, new_calculate}, 32'd0);

    // Random traffic with occasional mid-operation reset pulses
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      if ($urandom_range(299) == 0) begin
        #1 rst = 1'b1;
        model_reset();
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
